// File: rtl/exa_crosb_pkg.sv
// ---------------------------------------------------------------------------
// exa_crosb_pkg
// Shared declarations for the crossbar VC demultiplexer slice:
//   - routeState_e : route FSM states (IDLE, LOCKED, DROP)
//   - readyIndex   : flattens an (output, VC) pair into the READY_i bit index
// The FIFO entry struct depends on the top-level widths, so it is declared
// inside the top module where those parameters are in scope.
// ---------------------------------------------------------------------------
package exa_crosb_pkg;

   // IDLE expects a head beat, LOCKED is mid-packet, DROP discards an
   // illegally addressed packet (only reachable when the range check is built).
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCKED = 2'd1,
      DROP   = 2'd2
   } routeState_e;

   // READY_i is laid out output-major: bit sel*vcNum+vc belongs to (sel, vc).
   function automatic int unsigned readyIndex(input int unsigned sel,
                                              input int unsigned vc,
                                              input int unsigned vcNum);
      return sel * vcNum + vc;
   endfunction

endpackage

// File: rtl/exa_crosb_skid2.sv
// ---------------------------------------------------------------------------
// exa_crosb_skid2
// Generic 2-entry register FIFO. slot0 is always the head so the consumer
// sees a registered head with no mux behind it.
// Ports:
//   clk_i    : clock, rising edge
//   rstN_i   : asynchronous active-low reset
//   push_i   : write data_i (ignored while full)
//   data_i   : payload to write
//   pop_i    : drop the head entry (ignored while empty)
//   head_o   : current head entry (slot0)
//   count_o  : occupancy, 0..2
// ---------------------------------------------------------------------------
module exa_crosb_skid2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rstN_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [1:0]       count_o
);

   logic [WIDTH-1:0] slot0_q, slot0_d;
   logic [WIDTH-1:0] slot1_q, slot1_d;
   logic [1:0]       count_q, count_d;
   logic             doPush, doPop;

   assign doPush  = push_i && (count_q != 2'd2);
   assign doPop   = pop_i && (count_q != 2'd0);
   assign head_o  = slot0_q;
   assign count_o = count_q;

   // Next-state for the two slots. A simultaneous push and pop can only happen
   // with one entry held (push is blocked when full), so the new beat lands
   // directly in the head slot and occupancy stays at one.
   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      count_d = count_q;
      unique case ({doPush, doPop})
         2'b10: begin
            if (count_q == 2'd0) slot0_d = data_i;
            else                 slot1_d = data_i;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            slot0_d = data_i;
         end
         default: begin
         end
      endcase
   end

   // Storage registers; reset empties the FIFO and clears the payload so no
   // stale beat can leak out afterwards.
   always_ff @(posedge clk_i or negedge rstN_i) begin
      if (!rstN_i) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= 2'd0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/exa_crosb_vc_demux.sv
// ---------------------------------------------------------------------------
// exa_crosb_vc_demux
// Registered, packet-locked, VC-aware 1-to-OUTPUT_NUM demultiplexer. The head
// beat's SEL_i/VC_i pick the destination, which is held until LAST. Two beats
// of buffering keep READY_o a pure register decode, independent of READY_i.
// Optional feature macro: EXA_CROSB_DEMUX_CHECK_EN (destination range check,
// DROP state and sticky ERR_o). Without it ERR_o is tied low.
// Ports:
//   CLK_i, RESETN_i          : clock and asynchronous active-low reset
//   DATA_i/VALID_i/LAST_i/
//   PRIO_i/SEL_i/VC_i/READY_o: input beat stream and its accept
//   DATA_o/VALID_o/LAST_o/
//   PRIO_o/VC_o              : per-output beat, only the head's output active
//   READY_i                  : per (output,VC) ready, bit sel*VC_NUM+vc
//   ERR_o                    : sticky illegal-destination flag
// ---------------------------------------------------------------------------
module exa_crosb_vc_demux
   import exa_crosb_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int OUTPUT_NUM = 16,
   parameter int VC_NUM     = 2,
   parameter int SEL_WIDTH  = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1,
   parameter int VC_WIDTH   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
   input  logic                                  CLK_i,
   input  logic                                  RESETN_i,
   input  logic [DATA_WIDTH-1:0]                 DATA_i,
   input  logic                                  VALID_i,
   input  logic                                  LAST_i,
   input  logic                                  PRIO_i,
   input  logic [SEL_WIDTH-1:0]                  SEL_i,
   input  logic [VC_WIDTH-1:0]                   VC_i,
   output logic                                  READY_o,
   output logic [OUTPUT_NUM-1:0][DATA_WIDTH-1:0] DATA_o,
   output logic [OUTPUT_NUM-1:0]                 VALID_o,
   output logic [OUTPUT_NUM-1:0]                 LAST_o,
   output logic [OUTPUT_NUM-1:0]                 PRIO_o,
   output logic [OUTPUT_NUM-1:0][VC_WIDTH-1:0]   VC_o,
   input  logic [OUTPUT_NUM*VC_NUM-1:0]          READY_i,
   output logic                                  ERR_o
);

   localparam int READY_NUM = OUTPUT_NUM * VC_NUM;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
      logic                  prio;
      logic [SEL_WIDTH-1:0]  sel;
      logic [VC_WIDTH-1:0]   vc;
   } fifoEntry_t;

   routeState_e          state_q;
   logic [SEL_WIDTH-1:0] sel_q;
   logic [VC_WIDTH-1:0]  vc_q;
   fifoEntry_t           pushEntry, headEntry;
   logic [1:0]           fifoCount;
   logic                 accept, headBeat, pushEn, popEn, notEmpty;
   logic [READY_NUM-1:0] readyMask;

   assign READY_o  = (fifoCount < 2'd2);
   assign accept   = VALID_i && READY_o;
   assign headBeat = (state_q == IDLE);
   assign notEmpty = (fifoCount != 2'd0);

`ifdef EXA_CROSB_DEMUX_CHECK_EN
   logic illegalDest;
   logic err_q;

   // Widened compare so the check stays meaningful when OUTPUT_NUM or VC_NUM
   // is not a power of two.
   assign illegalDest = (32'(SEL_i) >= 32'(OUTPUT_NUM)) || (32'(VC_i) >= 32'(VC_NUM));
   assign pushEn      = accept && (state_q != DROP) && !(headBeat && illegalDest);
   assign ERR_o       = err_q;
`else
   assign pushEn = accept;
   assign ERR_o  = 1'b0;
`endif

   // Route FSM. The head beat's destination is captured so later beats of the
   // same packet follow it regardless of what SEL_i/VC_i do mid-packet.
   always_ff @(posedge CLK_i or negedge RESETN_i) begin
      if (!RESETN_i) begin
         state_q <= IDLE;
         sel_q   <= '0;
         vc_q    <= '0;
`ifdef EXA_CROSB_DEMUX_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else if (accept) begin
         unique case (state_q)
            IDLE: begin
`ifdef EXA_CROSB_DEMUX_CHECK_EN
               if (illegalDest) begin
                  err_q   <= 1'b1;
                  state_q <= LAST_i ? IDLE : DROP;
               end else begin
                  sel_q   <= SEL_i;
                  vc_q    <= VC_i;
                  state_q <= LAST_i ? IDLE : LOCKED;
               end
`else
               sel_q   <= SEL_i;
               vc_q    <= VC_i;
               state_q <= LAST_i ? IDLE : LOCKED;
`endif
            end
            LOCKED:  if (LAST_i) state_q <= IDLE;
            DROP:    if (LAST_i) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // The head beat takes its tag straight from the inputs because sel_q/vc_q
   // only become valid after this edge.
   always_comb begin
      pushEntry.data = DATA_i;
      pushEntry.last = LAST_i;
      pushEntry.prio = PRIO_i;
      pushEntry.sel  = headBeat ? SEL_i : sel_q;
      pushEntry.vc   = headBeat ? VC_i  : vc_q;
   end

   // Pop only when the specific (output, VC) the head targets is ready; a
   // stalled destination blocks everything behind it.
   assign readyMask = READY_NUM'(1) << readyIndex(32'(headEntry.sel), 32'(headEntry.vc), VC_NUM);
   assign popEn     = notEmpty && |(READY_i & readyMask);

   exa_crosb_skid2 #(
      .WIDTH ($bits(fifoEntry_t))
   ) uSkid (
      .clk_i   (CLK_i),
      .rstN_i  (RESETN_i),
      .push_i  (pushEn),
      .data_i  (pushEntry),
      .pop_i   (popEn),
      .head_o  (headEntry),
      .count_o (fifoCount)
   );

   // Output decode straight from the FIFO head registers: only the head's
   // output is driven, every other output is held at zero on all fields.
   always_comb begin
      VALID_o = '0;
      DATA_o  = '0;
      LAST_o  = '0;
      PRIO_o  = '0;
      VC_o    = '0;
      for (int o = 0; o < OUTPUT_NUM; o++) begin
         if (notEmpty && (32'(headEntry.sel) == o)) begin
            VALID_o[o] = 1'b1;
            DATA_o[o]  = headEntry.data;
            LAST_o[o]  = headEntry.last;
            PRIO_o[o]  = headEntry.prio;
            VC_o[o]    = headEntry.vc;
         end
      end
   end

endmodule

// File: tb/tb_exa_crosb_vc_demux.sv
// ---------------------------------------------------------------------------
// tb_exa_crosb_vc_demux
// Directed self-checking bench for exa_crosb_vc_demux. When
// EXA_CROSB_DEMUX_CHECK_EN is defined the DUT is built with 12 outputs and the
// illegal-destination scenario is exercised as well.
// ---------------------------------------------------------------------------
module tb_exa_crosb_vc_demux;

   localparam int DW = 128;
`ifdef EXA_CROSB_DEMUX_CHECK_EN
   localparam int OUT_N = 12;
`else
   localparam int OUT_N = 16;
`endif
   localparam int VCN = 2;
   localparam logic [3:0] LAST_OUT = 4'(OUT_N - 1);

   logic                       clk;
   logic                       resetN;
   logic [DW-1:0]              dataIn;
   logic                       validIn, lastIn, prioIn;
   logic [3:0]                 selIn;
   logic [0:0]                 vcIn;
   logic                       readyOut;
   logic [OUT_N-1:0][DW-1:0]   DATA_o;
   logic [OUT_N-1:0]           VALID_o, LAST_o, PRIO_o;
   logic [OUT_N-1:0][0:0]      VC_o;
   logic [OUT_N*VCN-1:0]       readyIn;
   logic                       errOut;

   int compared   = 0;
   int mismatched = 0;

   exa_crosb_vc_demux #(
      .DATA_WIDTH (DW),
      .OUTPUT_NUM (OUT_N),
      .VC_NUM     (VCN)
   ) dut (
      .CLK_i    (clk),
      .RESETN_i (resetN),
      .DATA_i   (dataIn),
      .VALID_i  (validIn),
      .LAST_i   (lastIn),
      .PRIO_i   (prioIn),
      .SEL_i    (selIn),
      .VC_i     (vcIn),
      .READY_o  (readyOut),
      .DATA_o   (DATA_o),
      .VALID_o  (VALID_o),
      .LAST_o   (LAST_o),
      .PRIO_o   (PRIO_o),
      .VC_o     (VC_o),
      .READY_i  (readyIn),
      .ERR_o    (errOut)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1ns past it before anyone samples.
   task automatic tickClock();
      @(posedge clk);
      #1;
   endtask

   // Drive one input beat (or an idle cycle when valid is 0).
   task automatic applyStimulus(input logic valid, input logic last, input logic prio,
                                input logic [3:0] sel, input logic vc,
                                input logic [DW-1:0] data);
      validIn = valid;
      lastIn  = last;
      prioIn  = prio;
      selIn   = sel;
      vcIn    = vc;
      dataIn  = data;
   endtask

   // Single comparison point: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Expect exactly one output (idx) presenting the given beat and every
   // other output completely quiet.
   task automatic checkPresented(input string tag, input logic [3:0] idx,
                                 input logic [DW-1:0] data, input logic last,
                                 input logic prio, input logic vc);
      logic [OUT_N-1:0] onehot;
      logic [DW-1:0]    others;
      onehot = OUT_N'(1) << idx;
      others = '0;
      for (int o = 0; o < OUT_N; o++) begin
         if (o != int'(idx)) others = others | DATA_o[o] | DW'(VC_o[o]);
      end
      checkOutput({tag, "_valid"}, DW'(VALID_o), DW'(onehot));
      checkOutput({tag, "_data"},  DATA_o[idx], data);
      checkOutput({tag, "_last"},  DW'(LAST_o), last ? DW'(onehot) : '0);
      checkOutput({tag, "_prio"},  DW'(PRIO_o), prio ? DW'(onehot) : '0);
      checkOutput({tag, "_vc"},    DW'(VC_o[idx]), DW'(vc));
      checkOutput({tag, "_others"}, others, '0);
   endtask

   // Directed scenario sequence.
   initial begin
      resetN  = 1'b0;
      readyIn = '1;
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, '0);
      tickClock();
      tickClock();

      // Reset state
      checkOutput("rst_ready", DW'(readyOut), DW'(1));
      checkOutput("rst_valid", DW'(VALID_o), '0);
      checkOutput("rst_fields", DW'(|{DATA_o, LAST_o, PRIO_o, VC_o}), '0);
      checkOutput("rst_err", DW'(errOut), '0);
      resetN = 1'b1;
      tickClock();

      // Single-beat packet to (5,1)
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd5, 1'b1, {4{32'hA1A1_0001}});
      tickClock();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, '0);
      checkPresented("single", 4'd5, {4{32'hA1A1_0001}}, 1'b1, 1'b1, 1'b1);
      checkOutput("single_err", DW'(errOut), '0);
      tickClock();
      checkOutput("single_drain", DW'(VALID_o), '0);

      // 4-beat packet locked to output 3 while SEL_i/VC_i wander to (7,1)
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, (k == 3), 1'b0, (k == 0) ? 4'd3 : 4'd7, (k != 0),
                       DW'(32'hB000_0000 + k));
         tickClock();
         checkPresented($sformatf("lock%0d", k), 4'd3, DW'(32'hB000_0000 + k),
                        (k == 3), 1'b0, 1'b0);
         checkOutput($sformatf("lock%0d_ready", k), DW'(readyOut), DW'(1));
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, '0);
      tickClock();
      checkOutput("lock_drain", DW'(VALID_o), '0);

      // Backpressure on (2,0) for 5 edges
      readyIn[4] = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd2, 1'b0, DW'(32'hC0));
      tickClock();
      checkPresented("bp_c0", 4'd2, DW'(32'hC0), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd2, 1'b0, DW'(32'hC1));
      tickClock();
      checkOutput("bp_full_ready", DW'(readyOut), '0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd2, 1'b0, DW'(32'hC2));
      for (int k = 0; k < 3; k++) begin
         tickClock();
         checkOutput($sformatf("bp_stall%0d_data", k), DATA_o[2], DW'(32'hC0));
         checkOutput($sformatf("bp_stall%0d_valid", k), DW'(VALID_o), DW'(16'h0004));
         checkOutput($sformatf("bp_stall%0d_ready", k), DW'(readyOut), '0);
      end
      readyIn[4] = 1'b1;
      tickClock();
      checkPresented("bp_c1", 4'd2, DW'(32'hC1), 1'b0, 1'b0, 1'b0);
      checkOutput("bp_rel_ready", DW'(readyOut), DW'(1));
      tickClock();
      checkPresented("bp_c2", 4'd2, DW'(32'hC2), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd9, 1'b1, DW'(32'hC3));
      tickClock();
      checkPresented("bp_c3", 4'd2, DW'(32'hC3), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, '0);
      tickClock();
      checkOutput("bp_drain", DW'(VALID_o), '0);

      // Packets to output 0 then the last output, output 0 stalled 3 edges
      readyIn[0] = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, DW'(32'hD0));
      tickClock();
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, DW'(32'hD1));
      tickClock();
      applyStimulus(1'b1, 1'b0, 1'b1, LAST_OUT, 1'b1, DW'(32'hE0));
      tickClock();
      checkPresented("hol_d0", 4'd0, DW'(32'hD0), 1'b0, 1'b0, 1'b0);
      readyIn[0] = 1'b1;
      tickClock();
      checkPresented("hol_d1", 4'd0, DW'(32'hD1), 1'b1, 1'b0, 1'b0);
      tickClock();
      checkPresented("hol_e0", LAST_OUT, DW'(32'hE0), 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd1, 1'b0, DW'(32'hE1));
      tickClock();
      checkPresented("hol_e1", LAST_OUT, DW'(32'hE1), 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, '0);
      tickClock();
      checkOutput("hol_drain", DW'(VALID_o), '0);

`ifdef EXA_CROSB_DEMUX_CHECK_EN
      // Illegal destination 13 on a 12-output build, 3-beat packet dropped
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd13, 1'b0, DW'(32'hF0));
      tickClock();
      checkOutput("chk_h0_valid", DW'(VALID_o), '0);
      checkOutput("chk_h0_err", DW'(errOut), DW'(1));
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd1, 1'b0, DW'(32'hF1));
      tickClock();
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, DW'(32'hF2));
      tickClock();
      checkOutput("chk_h2_valid", DW'(VALID_o), '0);
      checkOutput("chk_h2_ready", DW'(readyOut), DW'(1));
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, DW'(32'hF3));
      tickClock();
      checkPresented("chk_legal", 4'd1, DW'(32'hF3), 1'b1, 1'b0, 1'b0);
      checkOutput("chk_err_sticky", DW'(errOut), DW'(1));
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, '0);
      tickClock();
`else
      checkOutput("err_tied", DW'(errOut), '0);
`endif

      // Reset mid-packet with two beats buffered towards stalled (4,1)
      readyIn[9] = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd4, 1'b1, DW'(32'h60));
      tickClock();
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd4, 1'b1, DW'(32'h61));
      tickClock();
      checkPresented("mid_f0", 4'd4, DW'(32'h60), 1'b0, 1'b0, 1'b1);
      checkOutput("mid_full", DW'(readyOut), '0);
      resetN = 1'b0;
      #1;
      checkOutput("mid_rst_valid", DW'(VALID_o), '0);
      checkOutput("mid_rst_ready", DW'(readyOut), DW'(1));
      checkOutput("mid_rst_err", DW'(errOut), '0);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, '0);
      tickClock();
      resetN  = 1'b1;
      readyIn = '1;
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd6, 1'b0, DW'(32'h70));
      tickClock();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, '0);
      checkPresented("post_rst", 4'd6, DW'(32'h70), 1'b1, 1'b0, 1'b0);
      tickClock();
      checkOutput("post_rst_drain", DW'(VALID_o), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
